wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Final (write-back) pipeline stage, directly downstream of the memory stage.
- Consumes the MS-to-WS bus and commits results to the register file with per-byte strobes, so LWL/LWR partial writes are supported.
- Hosts the CP0 subset (BadVAddr, Count, Compare, Status, Cause, EPC), interrupt detection and exception/ERET commit.
- Drives the flush/redirect signals and the debug write-back trace.

Parameters:
EX_ENTRY  32'hBFC0_0380  exception handler entry PC
MS_TO_WS_BUS_WD  124  input bus width

Ports:
clk  in  1  clock
resetn  in  1  synchronous reset, active-low
ms_to_ws_valid  in  1  MS has a valid instruction (already gated by ws_ex/ws_eret upstream)
ms_to_ws_bus  in  124  {excode[123:119], badvaddr[118:87], cp0_addr[86:79]={rd,sel}, ex[78], bd[77], eret[76], syscall[75], mfc0[74], mtc0[73], gr_strb[72:69], dest[68:64], result[63:32], pc[31:0]}
ws_allowin  out  1  stage can accept
ext_int  in  6  hardware interrupt lines, level, into Cause.IP[15:10]
rf_we  out  4  register-file byte write strobes
rf_waddr  out  5  write register number
rf_wdata  out  32  write data
ws_fwd_blk_bus  out  42  {fwd_valid[41:38], dest[37:33], data[32:1], blk[0]}
ws_ex  out  1  exception or interrupt committing this cycle
ws_eret  out  1  ERET committing this cycle
ws_redirect_pc  out  32  EX_ENTRY when ws_ex, EPC when ws_eret
debug_wb_pc  out  32  trace PC
debug_wb_rf_wen  out  4  equals rf_we
debug_wb_rf_wnum  out  5  equals rf_waddr
debug_wb_rf_wdata  out  32  equals rf_wdata

Behaviour:
- Clock and reset: single clock clk; resetn synchronous, active-low, sampled on posedge clk.
- Reset values:
  - ws_valid=0, so every output strobe (rf_we, ws_ex, ws_eret, fwd_valid) is 0.
  - Status=32'h0040_0000 (BEV=1); Cause=0; Count=0; Compare=0; EPC=0; BadVAddr=0; tick=0.
- Handshake:
  - ws_ready_go=1; ws_allowin = !ws_valid || ws_ready_go (always 1).
  - On ws_allowin: ws_valid <= ms_to_ws_valid, and the bus register loads when ms_to_ws_valid.
  - Latency: one cycle from capture to commit.
- Interrupt:
  - int_pend = Status.IE && !Status.EXL && |(Cause.IP[15:8] & Status.IM[15:8]).
  - Sampled only when ws_valid; interrupt takes priority over the instruction's own ex, with ExcCode=0.
- Exception commit:
  - ws_ex = ws_valid && (int_pend || ex); ws_eret = ws_valid && eret && !ws_ex.
  - On ws_ex:
    - If Status.EXL=0: EPC <= bd ? pc-4 : pc, and Cause.BD <= bd.
    - Status.EXL <= 1; Cause.ExcCode <= int_pend ? 0 : excode.
    - BadVAddr <= badvaddr only if !int_pend and excode is 4 (AdEL) or 5 (AdES).
  - On ws_eret: Status.EXL <= 0.
- Register write:
  - rf_we = {4{ws_valid && !ws_ex}} & gr_strb; rf_waddr = dest.
  - rf_wdata = mfc0 ? cp0_rdata : result.
  - ERET and SYSCALL carry gr_strb=0.
- CP0 read: cp0_rdata muxed by cp0_addr:
  - 8'h40 BadVAddr, 8'h48 Count, 8'h58 Compare, 8'h60 Status, 8'h68 Cause, 8'h70 EPC; any other address reads 0.
- MTC0 writes: when ws_valid && mtc0 && !ws_ex, the write data is result. Writable fields:
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[9:8].
  - Count, Compare, EPC: full 32 bits.
  - BadVAddr and all other fields are read-only.
- Timer:
  - tick toggles every cycle; Count increments when tick=1 (every 2 cycles), wrapping 32'hFFFF_FFFF -> 0.
  - Cause.TI (bit 30) is set when Count==Compare; Cause.IP[7] = TI.
  - Cause.IP[15:10] = ext_int, sampled every cycle.
- Simultaneous-event priority:
  - An MTC0 to Count overrides the increment.
  - An MTC0 to Compare clears TI and overrides a same-cycle match set.
  - Exception update overrides an MTC0 from the same instruction, which is suppressed.
- Forwarding:
  - fwd_valid = rf_we; data = rf_wdata; dest = dest; blk = 0.
- Redirect:
  - ws_redirect_pc is valid only while ws_ex or ws_eret is high.
- Reset mid-operation: all CP0 state and ws_valid return to reset values the next edge; in-flight instruction discarded with no RF write.

Test Plan:
- Reset then ADDU-style bus (gr_strb=4'hF, dest=5, result=32'h1234, pc=32'hBFC0_0010) -> next cycle rf_we=4'hF, rf_waddr=5, rf_wdata=32'h1234, debug_wb_pc=32'hBFC0_0010.
- LWL commit with gr_strb=4'b1100 -> rf_we=4'b1100; fwd_valid=4'b1100.
- Load with ex=1, excode=4, badvaddr=32'h1001, bd=1, pc=32'hBFC0_0100:
  - ws_ex=1, ws_redirect_pc=32'hBFC0_0380, rf_we=0.
  - Afterwards EPC=32'hBFC0_00FC, Cause.BD=1, ExcCode=4, BadVAddr=32'h1001, EXL=1.
- MTC0 Compare=8 after Count reset -> Count reaches 8 at cycle 16.
  - Cause.TI=1 and Cause.IP[7]=1.
  - With Status=32'h0040_8001, the next valid instruction takes ws_ex with ExcCode=0.
  - A later MTC0 Compare clears TI.
- ERET in WB with EPC=32'hBFC0_0200 -> ws_eret=1, ws_redirect_pc=32'hBFC0_0200, EXL=0 next cycle.
- Exception while EXL=1 -> EPC unchanged; resetn=0 mid-stream -> rf_we=0 and Status=32'h0040_0000 next cycle.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: commits MS results to the register file with byte strobes,
// hosts the CP0 subset, detects interrupts and commits exceptions/ERET.
module wb_stage #(
  parameter logic [31:0] EX_ENTRY        = 32'hBFC0_0380,
  parameter int          MS_TO_WS_BUS_WD = 124
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic                       ws_allowin,
  input  logic [5:0]                 ext_int,
  output logic [3:0]                 rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic [41:0]                ws_fwd_blk_bus,
  output logic                       ws_ex,
  output logic                       ws_eret,
  output logic [31:0]                ws_redirect_pc,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);

  typedef enum logic [7:0] {
    CP0_BADVADDR = 8'h40,
    CP0_COUNT    = 8'h48,
    CP0_COMPARE  = 8'h58,
    CP0_STATUS   = 8'h60,
    CP0_CAUSE    = 8'h68,
    CP0_EPC      = 8'h70
  } cp0_reg_e;

  logic                       ws_valid;
  logic                       ws_ready_go;
  logic [MS_TO_WS_BUS_WD-1:0] bus_r;

  logic [4:0]  ws_excode;
  logic [31:0] ws_badvaddr;
  logic [7:0]  ws_cp0_addr;
  logic        ws_exc_flag, ws_bd, ws_eret_flag, ws_syscall, ws_mfc0, ws_mtc0;
  logic [3:0]  ws_gr_strb;
  logic [4:0]  ws_dest;
  logic [31:0] ws_result, ws_pc;

  assign ws_excode    = bus_r[123:119];
  assign ws_badvaddr  = bus_r[118:87];
  assign ws_cp0_addr  = bus_r[86:79];
  assign ws_exc_flag  = bus_r[78];
  assign ws_bd        = bus_r[77];
  assign ws_eret_flag = bus_r[76];
  assign ws_syscall   = bus_r[75];
  assign ws_mfc0      = bus_r[74];
  assign ws_mtc0      = bus_r[73];
  assign ws_gr_strb   = bus_r[72:69];
  assign ws_dest      = bus_r[68:64];
  assign ws_result    = bus_r[63:32];
  assign ws_pc        = bus_r[31:0];

  // SYSCALL is already folded into ex/excode by earlier stages.
  logic unused_syscall;
  assign unused_syscall = ws_syscall;

  assign ws_ready_go = 1'b1;
  assign ws_allowin  = !ws_valid || ws_ready_go;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ws_valid <= 1'b0;
      bus_r    <= '0;
    end else if (ws_allowin) begin
      ws_valid <= ms_to_ws_valid;
      if (ms_to_ws_valid) bus_r <= ms_to_ws_bus;
    end
  end

  logic [31:0] cp0_badvaddr, cp0_count, cp0_compare, cp0_epc;
  logic [7:0]  status_im;
  logic        status_exl, status_ie;
  logic        cause_bd, cause_ti;
  logic [1:0]  cause_ip_sw;
  logic [5:0]  ext_int_q;
  logic [4:0]  cause_excode;
  logic        tick;

  logic [7:0]  cause_ip;
  logic [31:0] cp0_status, cp0_cause, cp0_rdata;
  logic        int_pend, mtc0_we;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  // Timer interrupt shares IP[7] with the top external line.
  assign cause_ip   = {ext_int_q[5] | cause_ti, ext_int_q[4:0], cause_ip_sw};
  assign cp0_status = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
  assign cp0_cause  = {cause_bd, cause_ti, 14'd0, cause_ip, 1'b0, cause_excode, 2'b00};

  assign int_pend = status_ie && !status_exl && (|(cause_ip & status_im));
  assign ws_ex    = ws_valid && (int_pend || ws_exc_flag);
  assign ws_eret  = ws_valid && ws_eret_flag && !ws_ex;
  assign mtc0_we  = ws_valid && ws_mtc0 && !ws_ex;

  assign wr_count   = mtc0_we && (ws_cp0_addr == CP0_COUNT);
  assign wr_compare = mtc0_we && (ws_cp0_addr == CP0_COMPARE);
  assign wr_status  = mtc0_we && (ws_cp0_addr == CP0_STATUS);
  assign wr_cause   = mtc0_we && (ws_cp0_addr == CP0_CAUSE);
  assign wr_epc     = mtc0_we && (ws_cp0_addr == CP0_EPC);

  always_comb begin
    cp0_rdata = '0;
    case (ws_cp0_addr)
      CP0_BADVADDR: cp0_rdata = cp0_badvaddr;
      CP0_COUNT:    cp0_rdata = cp0_count;
      CP0_COMPARE:  cp0_rdata = cp0_compare;
      CP0_STATUS:   cp0_rdata = cp0_status;
      CP0_CAUSE:    cp0_rdata = cp0_cause;
      CP0_EPC:      cp0_rdata = cp0_epc;
      default:      cp0_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cp0_badvaddr <= '0;
      cp0_count    <= '0;
      cp0_compare  <= '0;
      cp0_epc      <= '0;
      status_im    <= '0;
      status_exl   <= 1'b0;
      status_ie    <= 1'b0;
      cause_bd     <= 1'b0;
      cause_ti     <= 1'b0;
      cause_ip_sw  <= '0;
      ext_int_q    <= '0;
      cause_excode <= '0;
      tick         <= 1'b0;
    end else begin
      tick      <= ~tick;
      ext_int_q <= ext_int;

      if (wr_count)  cp0_count <= ws_result;
      else if (tick) cp0_count <= cp0_count + 32'd1;

      if (wr_compare) cp0_compare <= ws_result;

      if (wr_compare)                    cause_ti <= 1'b0;
      else if (cp0_count == cp0_compare) cause_ti <= 1'b1;

      // MTC0 side effects are already masked by ws_ex, so no ordering clash here.
      if (ws_ex) begin
        if (!status_exl) begin
          cp0_epc  <= ws_bd ? (ws_pc - 32'd4) : ws_pc;
          cause_bd <= ws_bd;
        end
        status_exl   <= 1'b1;
        cause_excode <= int_pend ? 5'd0 : ws_excode;
        if (!int_pend && (ws_excode == 5'd4 || ws_excode == 5'd5))
          cp0_badvaddr <= ws_badvaddr;
      end else if (ws_eret) begin
        status_exl <= 1'b0;
      end

      if (wr_status) begin
        status_im  <= ws_result[15:8];
        status_exl <= ws_result[1];
        status_ie  <= ws_result[0];
      end
      if (wr_cause) cause_ip_sw <= ws_result[9:8];
      if (wr_epc)   cp0_epc     <= ws_result;
    end
  end

  assign rf_we          = {4{ws_valid && !ws_ex}} & ws_gr_strb;
  assign rf_waddr       = ws_dest;
  assign rf_wdata       = ws_mfc0 ? cp0_rdata : ws_result;
  assign ws_fwd_blk_bus = {rf_we, rf_waddr, rf_wdata, 1'b0};
  assign ws_redirect_pc = ws_ex ? EX_ENTRY : cp0_epc;

  assign debug_wb_pc       = ws_pc;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios with literal expectations plus random
// traffic, all cross-checked every cycle against a behavioural CP0/commit model.
module tb_wb_stage;

  typedef struct packed {
    logic [4:0]  excode;
    logic [31:0] badv;
    logic [7:0]  addr;
    logic        ex, bd, eret, sys, mfc0, mtc0;
    logic [3:0]  strb;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } instr_t;

  localparam logic [31:0] EXE = 32'hBFC0_0380;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ms_to_ws_valid;
  instr_t       in_i;
  logic [123:0] ms_to_ws_bus;
  logic         ws_allowin;
  logic [5:0]   ext_int;
  logic [3:0]   rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic [41:0]  ws_fwd_blk_bus;
  logic         ws_ex, ws_eret;
  logic [31:0]  ws_redirect_pc, debug_wb_pc;
  logic [3:0]   debug_wb_rf_wen;
  logic [4:0]   debug_wb_rf_wnum;
  logic [31:0]  debug_wb_rf_wdata;

  always #5 clk = ~clk;
  assign ms_to_ws_bus = in_i;

  wb_stage #(.EX_ENTRY(EXE), .MS_TO_WS_BUS_WD(124)) dut (
    .clk(clk), .resetn(resetn), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_to_ws_bus(ms_to_ws_bus), .ws_allowin(ws_allowin), .ext_int(ext_int),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_fwd_blk_bus(ws_fwd_blk_bus), .ws_ex(ws_ex), .ws_eret(ws_eret),
    .ws_redirect_pc(ws_redirect_pc), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_live = 1'b0;
  bit          m_valid;
  instr_t      m_i;
  logic [31:0] m_count, m_compare, m_epc, m_badv;
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [1:0]  m_sw;
  logic [5:0]  m_ext;
  logic [4:0]  m_code;
  int unsigned m_edges;

  function automatic logic [7:0] m_ip();
    return (8'(m_ext) << 2) | 8'(m_sw) | (8'(m_ti) << 7);
  endfunction
  function automatic logic [31:0] m_status();
    return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
  endfunction
  function automatic logic [31:0] m_cause();
    return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_code) << 2);
  endfunction
  function automatic logic m_int();
    return m_ie && !m_exl && ((m_ip() & m_im) != 8'd0);
  endfunction
  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h40:   return m_badv;
      8'h48:   return m_count;
      8'h58:   return m_compare;
      8'h60:   return m_status();
      8'h68:   return m_cause();
      8'h70:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic ex_now, eret_now, int_now, mt;
    if (!resetn) begin
      m_live = 1'b1; m_valid = 1'b0; m_i = '0;
      m_count = 0; m_compare = 0; m_epc = 0; m_badv = 0;
      m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_sw = 0; m_ext = 0; m_code = 0;
      m_edges = 0;
    end else begin
      int_now  = m_int();
      ex_now   = m_valid && (int_now || m_i.ex);
      eret_now = m_valid && m_i.eret && !ex_now;
      mt       = m_valid && m_i.mtc0 && !ex_now;
      if (mt && m_i.addr == 8'h58)    m_ti = 1'b0;
      else if (m_count == m_compare)  m_ti = 1'b1;
      if (mt && m_i.addr == 8'h48)    m_count = m_i.result;
      else if (m_edges % 2 == 1)      m_count = m_count + 1;
      if (mt && m_i.addr == 8'h58)    m_compare = m_i.result;
      if (ex_now) begin
        if (!m_exl) begin
          m_epc = m_i.bd ? m_i.pc - 4 : m_i.pc;
          m_bd  = m_i.bd;
        end
        m_exl  = 1'b1;
        m_code = int_now ? 5'd0 : m_i.excode;
        if (!int_now && (m_i.excode == 4 || m_i.excode == 5)) m_badv = m_i.badv;
      end else if (eret_now) m_exl = 1'b0;
      if (mt) begin
        case (m_i.addr)
          8'h60: begin m_im = m_i.result[15:8]; m_exl = m_i.result[1]; m_ie = m_i.result[0]; end
          8'h68: m_sw = m_i.result[9:8];
          8'h70: m_epc = m_i.result;
          default: ;
        endcase
      end
      m_ext   = ext_int;
      m_valid = ms_to_ws_valid;
      if (ms_to_ws_valid) m_i = in_i;
      m_edges++;
    end
  end

  always @(negedge clk) begin : compare
    logic e_ex, e_eret;
    logic [3:0]  e_we;
    logic [31:0] e_wd;
    if (m_live) begin
      e_ex   = m_valid && (m_int() || m_i.ex);
      e_eret = m_valid && m_i.eret && !e_ex;
      e_we   = (m_valid && !e_ex) ? m_i.strb : 4'd0;
      e_wd   = m_i.mfc0 ? m_read(m_i.addr) : m_i.result;
      chk("allowin", 32'(ws_allowin), 32'd1);
      chk("ws_ex", 32'(ws_ex), 32'(e_ex));
      chk("ws_eret", 32'(ws_eret), 32'(e_eret));
      chk("rf_we", 32'(rf_we), 32'(e_we));
      chk("fwd_valid", 32'(ws_fwd_blk_bus[41:38]), 32'(e_we));
      chk("fwd_blk", 32'(ws_fwd_blk_bus[0]), 32'd0);
      chk("dbg_wen", 32'(debug_wb_rf_wen), 32'(e_we));
      if (m_valid) begin
        chk("rf_waddr", 32'(rf_waddr), 32'(m_i.dest));
        chk("rf_wdata", rf_wdata, e_wd);
        chk("dbg_pc", debug_wb_pc, m_i.pc);
        chk("dbg_wnum", 32'(debug_wb_rf_wnum), 32'(m_i.dest));
        chk("dbg_wdata", debug_wb_rf_wdata, e_wd);
        chk("fwd_dest", 32'(ws_fwd_blk_bus[37:33]), 32'(m_i.dest));
        chk("fwd_data", ws_fwd_blk_bus[32:1], e_wd);
      end
      if (e_ex)        chk("redirect_ex", ws_redirect_pc, EXE);
      else if (e_eret) chk("redirect_eret", ws_redirect_pc, m_epc);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic instr_t alu(input logic [4:0] d, input logic [31:0] r,
                                 input logic [31:0] pc, input logic [3:0] s);
    instr_t t = '0;
    t.dest = d; t.result = r; t.pc = pc; t.strb = s;
    return t;
  endfunction
  function automatic instr_t rd0(input logic [7:0] a);
    instr_t t = alu(5'd2, 32'd0, 32'hBFC0_1000, 4'hF);
    t.mfc0 = 1'b1; t.addr = a;
    return t;
  endfunction
  function automatic instr_t wr0(input logic [7:0] a, input logic [31:0] d);
    instr_t t = alu(5'd0, d, 32'hBFC0_1004, 4'h0);
    t.mtc0 = 1'b1; t.addr = a;
    return t;
  endfunction

  task automatic issue(input instr_t t);
    ms_to_ws_valid = 1'b1;
    in_i = t;
    @(negedge clk); #1;
    ms_to_ws_valid = 1'b0;
  endtask

  logic [4:0] codes [7] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12, 5'd13};
  logic [7:0] addrs [7] = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h08};

  initial begin
    instr_t t;
    resetn = 1'b0; ms_to_ws_valid = 1'b0; in_i = '0; ext_int = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    chk("reset_ws_ex", 32'(ws_ex), 32'd0);
    resetn = 1'b1;

    issue(alu(5'd5, 32'h1234, 32'hBFC0_0010, 4'hF));
    chk("addu_we", 32'(rf_we), 32'hF);
    chk("addu_waddr", 32'(rf_waddr), 32'd5);
    chk("addu_wdata", rf_wdata, 32'h1234);
    chk("addu_pc", debug_wb_pc, 32'hBFC0_0010);

    issue(alu(5'd7, 32'hAABB_0000, 32'hBFC0_0014, 4'b1100));
    chk("lwl_we", 32'(rf_we), 32'hC);
    chk("lwl_fwd", 32'(ws_fwd_blk_bus[41:38]), 32'hC);

    t = alu(5'd8, 32'd0, 32'hBFC0_0100, 4'hF);
    t.ex = 1'b1; t.excode = 5'd4; t.badv = 32'h1001; t.bd = 1'b1;
    issue(t);
    chk("adel_ex", 32'(ws_ex), 32'd1);
    chk("adel_redirect", ws_redirect_pc, 32'hBFC0_0380);
    chk("adel_we", 32'(rf_we), 32'd0);
    issue(rd0(8'h70)); chk("adel_epc", rf_wdata, 32'hBFC0_00FC);
    issue(rd0(8'h68)); chk("adel_cause", rf_wdata & 32'h8000_007C, 32'h8000_0010);
    issue(rd0(8'h40)); chk("adel_badv", rf_wdata, 32'h1001);
    issue(rd0(8'h60)); chk("adel_status", rf_wdata, 32'h0040_0002);

    issue(wr0(8'h70, 32'hBFC0_0200));
    t = alu(5'd0, 32'd0, 32'hBFC0_0204, 4'h0); t.eret = 1'b1;
    issue(t);
    chk("eret_flag", 32'(ws_eret), 32'd1);
    chk("eret_redirect", ws_redirect_pc, 32'hBFC0_0200);
    issue(rd0(8'h60)); chk("eret_status", rf_wdata, 32'h0040_0000);

    issue(wr0(8'h48, 32'd0));
    issue(wr0(8'h58, 32'd8));
    issue(rd0(8'h68)); chk("ti_clear", rf_wdata & 32'h4000_0000, 32'd0);
    repeat (20) begin @(negedge clk); #1; end
    issue(rd0(8'h68)); chk("ti_set", rf_wdata & 32'h4000_8000, 32'h4000_8000);

    issue(wr0(8'h60, 32'h0040_8001));
    issue(alu(5'd9, 32'h55, 32'hBFC0_0300, 4'hF));
    chk("int_ex", 32'(ws_ex), 32'd1);
    chk("int_we", 32'(rf_we), 32'd0);
    issue(rd0(8'h68)); chk("int_code", rf_wdata & 32'h0000_007C, 32'd0);
    issue(rd0(8'h70)); chk("int_epc", rf_wdata, 32'hBFC0_0300);
    issue(wr0(8'h58, 32'h0000_1000));
    issue(rd0(8'h68)); chk("ti_clear2", rf_wdata & 32'h4000_0000, 32'd0);

    t = alu(5'd0, 32'd0, 32'hBFC0_0400, 4'h0); t.ex = 1'b1; t.excode = 5'd12;
    issue(t);
    chk("exl_ex", 32'(ws_ex), 32'd1);
    issue(rd0(8'h70)); chk("exl_epc", rf_wdata, 32'hBFC0_0300);

    ms_to_ws_valid = 1'b1; in_i = alu(5'd3, 32'h77, 32'hBFC0_0500, 4'hF);
    resetn = 1'b0;
    @(negedge clk); #1;
    chk("midrst_we", 32'(rf_we), 32'd0);
    ms_to_ws_valid = 1'b0; resetn = 1'b1;
    issue(rd0(8'h60)); chk("midrst_status", rf_wdata, 32'h0040_0000);

    for (int n = 0; n < 3000; n++) begin
      t = '0;
      t.dest   = 5'($urandom);
      t.result = $urandom;
      t.pc     = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      t.bd     = 1'($urandom);
      t.badv   = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: t.strb = 4'($urandom);
        4: begin t.mfc0 = 1'b1; t.strb = 4'hF; t.addr = addrs[$urandom_range(0, 6)]; end
        5, 6: begin
          t.mtc0 = 1'b1; t.addr = addrs[$urandom_range(0, 6)];
          if (t.addr == 8'h58 || t.addr == 8'h48) t.result = 32'($urandom_range(0, 40));
        end
        7: begin t.ex = 1'b1; t.excode = codes[$urandom_range(0, 6)]; t.strb = 4'($urandom); end
        8: t.eret = 1'b1;
        default: begin t.ex = 1'b1; t.sys = 1'b1; t.excode = 5'd8; end
      endcase
      in_i = t;
      ms_to_ws_valid = ($urandom_range(0, 3) != 0);
      ext_int = ($urandom_range(0, 15) == 0) ? 6'($urandom) : 6'd0;
      resetn = ($urandom_range(0, 199) != 0);
      @(negedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
